jnw_atr_osc_counter: RTL

//  Digital readout for the analog oscillator sensor built from the JNWATR NCH/PCH cells.
//  - Drives the oscillator enable.
//  - Waits a settle time, then counts rising edges of the asynchronous osc_in over a fixed clk gate window.
//  - Hands the count to the system bus side with a valid/ready handshake.
//  - Sits between the analog macro and the digital register/readout logic.

---
 rtl/jnw_atr_pkg.sv | 14 +
 rtl/jnw_atr_sync.sv | 26 ++
 rtl/jnw_atr_osc_counter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/jnw_atr_pkg.sv
// Shared types and constants for the JNWATR oscillator readout blocks.
`timescale 1ns/1ps
package jnw_atr_pkg;

  typedef enum logic [1:0] {
    ATR_IDLE,
    ATR_SETTLE,
    ATR_COUNT,
    ATR_DONE
  } atr_cnt_state_t;

  localparam int ATR_SYNC_STAGES_MIN = 2;

endpackage

// File: rtl/jnw_atr_sync.sv
// Flop-chain synchronizer for a single asynchronous bit; latency STAGES clk cycles, no backpressure.
// Depth is never allowed below the metastability minimum.
`timescale 1ns/1ps
module jnw_atr_sync
  import jnw_atr_pkg::*;
#(
  parameter int STAGES = ATR_SYNC_STAGES_MIN
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  localparam int N = (STAGES < ATR_SYNC_STAGES_MIN) ? ATR_SYNC_STAGES_MIN : STAGES;

  logic [N-1:0] chain;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) chain <= '0;
    else       chain <= {chain[N-2:0], d};
  end

  assign q = chain[N-1];

endmodule

// File: rtl/jnw_atr_osc_counter.sv
// Gated edge counter for the analog oscillator: enable, settle, count over a fixed window, hand off.
// Result appears SETTLE_CYCLES+GATE_CYCLES after start; held in DONE until ready (valid/ready handshake).
`timescale 1ns/1ps
module jnw_atr_osc_counter
  import jnw_atr_pkg::*;
#(
  parameter int CNT_W         = 16,
  parameter int GATE_CYCLES   = 1024,
  parameter int SETTLE_CYCLES = 64,
  parameter int SYNC_STAGES   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             osc_in,
  output logic             osc_en,
  output logic             busy,
  output logic [CNT_W-1:0] result,
  output logic             overflow,
  output logic             valid,
  input  logic             ready
);

  localparam int TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] GATE_LD   = TMR_W'(GATE_CYCLES - 1);
  localparam logic [TMR_W-1:0] SETTLE_LD = (SETTLE_CYCLES > 0) ? TMR_W'(SETTLE_CYCLES - 1) : '0;

  atr_cnt_state_t   state_q, state_d;
  logic             sync_q, prev_q, rise;
  logic [TMR_W-1:0] timer_q;
  logic             tmr_done;
  logic [CNT_W-1:0] cnt_q, cnt_inc;
  logic             ovf_q, ovf_inc;

  jnw_atr_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (osc_in),
    .q     (sync_q)
  );

  assign rise     = sync_q & ~prev_q;
  assign tmr_done = (timer_q == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ATR_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ATR_IDLE:   if (start) state_d = (SETTLE_CYCLES == 0) ? ATR_COUNT : ATR_SETTLE;
      ATR_SETTLE: if (tmr_done) state_d = ATR_COUNT;
      ATR_COUNT:  if (tmr_done) state_d = ATR_DONE;
      ATR_DONE:   if (ready) state_d = ATR_IDLE;
      default:    state_d = ATR_IDLE;
    endcase
  end

  // Saturating increment; the final-cycle edge is folded in before the result load.
  always_comb begin
    cnt_inc = cnt_q;
    ovf_inc = ovf_q;
    if (state_q == ATR_COUNT && rise) begin
      if (cnt_q == '1) ovf_inc = 1'b1;
      else             cnt_inc = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q   <= 1'b0;
      timer_q  <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      osc_en   <= 1'b0;
      busy     <= 1'b0;
      valid    <= 1'b0;
      result   <= '0;
      overflow <= 1'b0;
    end else begin
      prev_q <= sync_q;
      case (state_q)
        ATR_IDLE: begin
          if (start) begin
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            osc_en  <= 1'b1;
            busy    <= 1'b1;
            timer_q <= (SETTLE_CYCLES == 0) ? GATE_LD : SETTLE_LD;
          end
        end
        ATR_SETTLE: begin
          if (tmr_done) timer_q <= GATE_LD;
          else          timer_q <= timer_q - TMR_W'(1);
        end
        ATR_COUNT: begin
          cnt_q <= cnt_inc;
          ovf_q <= ovf_inc;
          if (tmr_done) begin
            timer_q  <= '0;
            result   <= cnt_inc;
            overflow <= ovf_inc;
            valid    <= 1'b1;
            busy     <= 1'b0;
            osc_en   <= 1'b0;
          end else begin
            timer_q <= timer_q - TMR_W'(1);
          end
        end
        ATR_DONE: begin
          if (ready) begin
            valid   <= 1'b0;
            timer_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
